// File: rtl/ss_pkt_checker.sv
// rtl/ss_pkt_checker.sv - ss stream sink: byte-length measurement, incrementing-pattern check, stats
// Optional LFSR backpressure on s_ready; per-packet result one cycle after the last beat.
module ss_pkt_checker #(
   parameter int          NUM_BYTES = 1,
   parameter int          USER_BITS = 1,
   parameter int          LEN_BITS  = 16,
   parameter int          CNT_BITS  = 32,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [8*NUM_BYTES-1:0] s_data,
   input  logic [NUM_BYTES-1:0]   s_keep,
   input  logic                   s_last,
   input  logic [USER_BITS-1:0]   s_user,
   input  logic                   bp_en,
   output logic                   res_valid,
   output logic [LEN_BITS-1:0]    res_len,
   output logic                   res_err,
   output logic [USER_BITS-1:0]   res_user,
   output logic [CNT_BITS-1:0]    pkt_cnt,
   output logic [CNT_BITS-1:0]    err_cnt
);
   localparam int CW = $clog2(NUM_BYTES + 1);
   localparam int AW = LEN_BITS + CW + 1;

   typedef enum logic {IDLE, BODY} state_t;

   state_t                r_state;
   logic [15:0]           r_lfsr;
   logic                  r_rdy_en;
   logic [7:0]            r_exp;
   logic [LEN_BITS-1:0]   r_len;
   logic                  r_err;
   logic [USER_BITS-1:0]  r_user;
   logic                  r_res_valid;
   logic [LEN_BITS-1:0]   r_res_len;
   logic                  r_res_err;
   logic [USER_BITS-1:0]  r_res_user;
   logic [CNT_BITS-1:0]   r_pkt_cnt;
   logic [CNT_BITS-1:0]   r_err_cnt;

   logic                  w_xfer;
   logic                  w_first;
   logic [7:0]            w_base;
   logic [NUM_BYTES-1:0]  w_mask;
   logic [CW-1:0]         w_add;
   logic                  w_pat_err;
   logic                  w_therm;
   logic                  w_keep_err;
   logic [LEN_BITS-1:0]   w_len_base;
   logic [AW-1:0]         w_sum;
   logic [LEN_BITS-1:0]   w_len_new;
   logic                  w_err_new;
   logic [USER_BITS-1:0]  w_user_new;
   logic [7:0]            w_exp_next;

   // Ready comes only from flops (and the static bp_en select), never from s_valid.
   assign s_ready    = r_rdy_en & (~bp_en | r_lfsr[0]);
   assign w_xfer     = s_valid & s_ready;
   assign w_first    = (r_state == IDLE);
   assign w_base     = w_first ? s_data[8*NUM_BYTES-1 -: 8] : r_exp;
   assign w_mask     = s_last ? s_keep : {NUM_BYTES{1'b1}};
   assign w_exp_next = w_base + 8'(NUM_BYTES);

   always_comb begin
      w_pat_err = 1'b0;
      w_add     = '0;
      for (int j = 0; j < NUM_BYTES; j++) begin
         if (w_mask[NUM_BYTES-1-j]) begin
            w_add = w_add + CW'(1);
            if (s_data[8*(NUM_BYTES-j)-1 -: 8] != (w_base + 8'(j)))
               w_pat_err = 1'b1;
         end
      end
   end

   // MSB-aligned thermometer: byte 0 valid and no valid byte after an invalid one.
   always_comb begin
      w_therm = s_keep[NUM_BYTES-1];
      for (int j = 1; j < NUM_BYTES; j++) begin
         if (s_keep[NUM_BYTES-1-j] && !s_keep[NUM_BYTES-j])
            w_therm = 1'b0;
      end
   end

   assign w_keep_err = s_last ? ~w_therm : (s_keep != {NUM_BYTES{1'b1}});
   assign w_len_base = w_first ? '0 : r_len;
   assign w_sum      = AW'(w_len_base) + AW'(w_add);
   assign w_len_new  = (|w_sum[AW-1:LEN_BITS]) ? '1 : w_sum[LEN_BITS-1:0];
   assign w_err_new  = (~w_first & r_err) | w_pat_err | w_keep_err;
   assign w_user_new = w_first ? s_user : r_user;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_lfsr      <= LFSR_SEED;
         r_rdy_en    <= 1'b0;
         r_exp       <= '0;
         r_len       <= '0;
         r_err       <= 1'b0;
         r_user      <= '0;
         r_res_valid <= 1'b0;
         r_res_len   <= '0;
         r_res_err   <= 1'b0;
         r_res_user  <= '0;
         r_pkt_cnt   <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_lfsr      <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
         r_rdy_en    <= 1'b1;
         r_res_valid <= 1'b0;
         if (w_xfer) begin
            if (s_last) begin
               r_state     <= IDLE;
               r_res_valid <= 1'b1;
               r_res_len   <= w_len_new;
               r_res_err   <= w_err_new;
               r_res_user  <= w_user_new;
               if (r_pkt_cnt != '1)
                  r_pkt_cnt <= r_pkt_cnt + CNT_BITS'(1);
               if (w_err_new && (r_err_cnt != '1))
                  r_err_cnt <= r_err_cnt + CNT_BITS'(1);
            end else begin
               r_state <= BODY;
               r_len   <= w_len_new;
               r_err   <= w_err_new;
               r_user  <= w_user_new;
               r_exp   <= w_exp_next;
            end
         end
      end
   end

   assign res_valid = r_res_valid;
   assign res_len   = r_res_len;
   assign res_err   = r_res_err;
   assign res_user  = r_res_user;
   assign pkt_cnt   = r_pkt_cnt;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ss_pkt_checker.sv
// tb/tb_ss_pkt_checker.sv - table-driven and sequence bench for ss_pkt_checker
module tb_ss_pkt_checker;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        s_valid, s_last, bp_en;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic [1:0]  s_user;

   logic        s_ready, res_valid, res_err;
   logic [15:0] res_len;
   logic [1:0]  res_user;
   logic [31:0] pkt_cnt, err_cnt;

   logic        sm_ready, sm_res_valid, sm_res_err;
   logic [3:0]  sm_res_len;
   logic [1:0]  sm_res_user;
   logic [1:0]  sm_pkt_cnt, sm_err_cnt;

   always #5 clk = ~clk;

   ss_pkt_checker #(.NUM_BYTES(4), .USER_BITS(2), .LEN_BITS(16), .CNT_BITS(32), .LFSR_SEED(16'hACE1)) u_dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .s_user(s_user), .bp_en(bp_en),
      .res_valid(res_valid), .res_len(res_len), .res_err(res_err), .res_user(res_user),
      .pkt_cnt(pkt_cnt), .err_cnt(err_cnt));

   ss_pkt_checker #(.NUM_BYTES(4), .USER_BITS(2), .LEN_BITS(4), .CNT_BITS(2), .LFSR_SEED(16'hACE1)) u_small (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sm_ready), .s_data(s_data),
      .s_keep(s_keep), .s_last(s_last), .s_user(s_user), .bp_en(bp_en),
      .res_valid(sm_res_valid), .res_len(sm_res_len), .res_err(sm_res_err), .res_user(sm_res_user),
      .pkt_cnt(sm_pkt_cnt), .err_cnt(sm_err_cnt));

   typedef struct {
      logic [15:0] len;
      logic        err;
      logic [1:0]  user;
   } res_t;

   typedef struct {
      int          nb;
      logic [7:0]  seed;
      logic [1:0]  user;
      logic [3:0]  lkeep;
      logic [3:0]  mkeep;
      int          cidx;
      logic [7:0]  cval;
      logic [15:0] exp_len;
      logic        exp_err;
   } vec_t;

   res_t  exp_q[$];
   vec_t  vecs[11];
   int    n_checks = 0;
   int    n_fail   = 0;
   logic  prev_last = 1'b0;
   logic [15:0] m_lfsr;
   logic        m_rdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference backpressure sequence from the seed, restarted by reset.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_lfsr <= 16'hACE1;
         m_rdy  <= 1'b0;
      end else begin
         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
         m_rdy  <= 1'b1;
      end
   end

   initial begin
      res_t e;
      logic exp_rdy;
      forever begin
         @(negedge clk);
         exp_rdy = rst ? (m_rdy & (~bp_en | m_lfsr[0])) : 1'b0;
         chk("s_ready", s_ready, exp_rdy);
         chk("sm_s_ready", sm_ready, exp_rdy);
         if (!rst) begin
            chk("res_valid_in_reset", res_valid, 1'b0);
            prev_last = 1'b0;
         end else begin
            if (res_valid || prev_last)
               chk("res_valid_latency", res_valid, prev_last);
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_result", 1'b1, 1'b0);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_len", res_len, e.len);
                  chk("res_err", res_err, e.err);
                  chk("res_user", res_user, e.user);
               end
            end
            prev_last = s_valid & s_ready & s_last;
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] u);
      logic acc = 1'b0;
      int   n = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_keep  = k;
      s_last  = l;
      s_user  = u;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("beat_accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_pkt(input int nb, input logic [7:0] seed, input logic [1:0] user,
                           input logic [3:0] lkeep, input logic [3:0] mkeep, input int cidx,
                           input logic [7:0] cval, input logic [15:0] elen, input logic eerr);
      logic [31:0] d;
      logic [7:0]  v;
      logic [3:0]  k;
      res_t        r;
      r.len  = elen;
      r.err  = eerr;
      r.user = user;
      exp_q.push_back(r);
      for (int b = 0; b < nb; b++) begin
         d = '0;
         for (int j = 0; j < 4; j++) begin
            v = seed + 8'(4*b + j);
            if (4*b + j == cidx) v = cval;
            d[31-8*j -: 8] = v;
         end
         k = (b == nb-1) ? lkeep : ((b == 0) ? mkeep : 4'hF);
         send_beat(d, k, (b == nb-1), (b == 0) ? user : ~user);
      end
   endtask

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      int         n_err;
      int         nb, kc;
      logic [3:0] ones, keep;
      s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_user = '0; bp_en = 1'b0;

      //            nb seed   user  lkeep mkeep cidx cval   len     err
      vecs[0]  = '{3, 8'h10, 2'd1, 4'hF, 4'hF, -1, 8'h00, 16'd12, 1'b0};
      vecs[1]  = '{3, 8'h10, 2'd2, 4'hC, 4'hF, -1, 8'h00, 16'd10, 1'b0};
      vecs[2]  = '{3, 8'h10, 2'd3, 4'hC, 4'hF,  5, 8'hFF, 16'd10, 1'b1};
      vecs[3]  = '{2, 8'hFE, 2'd0, 4'h8, 4'hF, -1, 8'h00, 16'd5,  1'b0};
      vecs[4]  = '{3, 8'h20, 2'd1, 4'hA, 4'hF, -1, 8'h00, 16'd10, 1'b1};
      vecs[5]  = '{2, 8'h44, 2'd2, 4'hF, 4'h7, -1, 8'h00, 16'd8,  1'b1};
      vecs[6]  = '{1, 8'h40, 2'd3, 4'hE, 4'hF, -1, 8'h00, 16'd3,  1'b0};
      vecs[7]  = '{1, 8'h41, 2'd0, 4'h0, 4'hF, -1, 8'h00, 16'd0,  1'b1};
      vecs[8]  = '{1, 8'h20, 2'd1, 4'h8, 4'hF,  2, 8'h00, 16'd1,  1'b0};
      vecs[9]  = '{2, 8'h30, 2'd2, 4'hF, 4'hF,  0, 8'h00, 16'd8,  1'b1};
      vecs[10] = '{1, 8'h70, 2'd3, 4'h1, 4'hF, -1, 8'h00, 16'd1,  1'b1};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_len", res_len, 16'd0);
      chk("rst_res_err", res_err, 1'b0);
      chk("rst_res_user", res_user, 2'd0);
      chk("rst_pkt_cnt", pkt_cnt, 32'd0);
      chk("rst_err_cnt", err_cnt, 32'd0);
      chk("rst_s_ready", s_ready, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_first_cycle", s_ready, 1'b0);
      @(negedge clk);
      chk("ready_second_cycle", s_ready, 1'b1);
      @(posedge clk);
      #1;

      // Directed table, packets sent back-to-back.
      n_err = 0;
      for (int i = 0; i < 11; i++) begin
         send_pkt(vecs[i].nb, vecs[i].seed, vecs[i].user, vecs[i].lkeep, vecs[i].mkeep,
                  vecs[i].cidx, vecs[i].cval, vecs[i].exp_len, vecs[i].exp_err);
         if (vecs[i].exp_err) n_err++;
      end
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("tbl_pkt_cnt", pkt_cnt, 32'd11);
      chk("tbl_err_cnt", err_cnt, 32'(n_err));
      chk("tbl_queue_drained", exp_q.size(), 0);
      chk("sm_pkt_cnt_sat", sm_pkt_cnt, 2'd3);
      chk("sm_err_cnt_sat", sm_err_cnt, 2'd3);

      // 20-byte packet: 4-bit length saturates at 15 without flagging an error.
      send_pkt(5, 8'h00, 2'd2, 4'hF, 4'hF, -1, 8'h00, 16'd20, 1'b0);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("sm_res_len_sat", sm_res_len, 4'd15);
      chk("sm_res_err_sat", sm_res_err, 1'b0);
      chk("sm_res_user", sm_res_user, 2'd2);

      // Random-length clean packets under LFSR backpressure.
      bp_en = 1'b1;
      ones  = 4'hF;
      for (int p = 0; p < 100; p++) begin
         nb   = int'($urandom_range(1, 6));
         kc   = int'($urandom_range(1, 4));
         keep = ones << (4 - kc);
         send_pkt(nb, 8'($urandom), 2'($urandom), keep, 4'hF, -1, 8'h00, 16'(4*(nb-1) + kc), 1'b0);
      end
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_pkt_cnt", pkt_cnt, 32'd112);
      chk("bp_err_cnt", err_cnt, 32'(n_err));
      chk("bp_queue_drained", exp_q.size(), 0);
      bp_en = 1'b0;
      @(posedge clk);
      #1;

      // Single-beat packets back-to-back, then reset in the middle of a 5-beat packet.
      send_pkt(1, 8'h60, 2'd1, 4'hF, 4'hF, -1, 8'h00, 16'd4, 1'b0);
      send_pkt(1, 8'hC3, 2'd2, 4'h8, 4'hF, -1, 8'h00, 16'd1, 1'b0);
      send_pkt(1, 8'h05, 2'd3, 4'hF, 4'hF,  3, 8'h00, 16'd4, 1'b1);
      send_beat(32'h50515253, 4'hF, 1'b0, 2'd3);
      send_beat(32'h54555657, 4'hF, 1'b0, 2'd3);
      s_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("abort_pkt_cnt", pkt_cnt, 32'd0);
      chk("abort_err_cnt", err_cnt, 32'd0);
      chk("abort_res_len", res_len, 16'd0);
      chk("abort_res_valid", res_valid, 1'b0);
      chk("abort_s_ready", s_ready, 1'b0);
      chk("abort_queue_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(2, 8'h90, 2'd2, 4'hE, 4'hF, -1, 8'h00, 16'd7, 1'b0);
      s_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_pkt_cnt", pkt_cnt, 32'd1);
      chk("post_rst_err_cnt", err_cnt, 32'd0);
      chk("post_rst_queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ss_pkt_checker.md
# ss_pkt_checker

Slave-end sink for the ss streaming interface. It accepts packets from any ss master, measures each packet's byte length, and checks the payload against an incrementing-byte pattern. It reports a per-packet result and keeps saturating statistics. Optional pseudo-random backpressure lets it sit at the end of a pipeline under test in simulation or on-chip loopback.

## Interface
- NUM_BYTES, 1: ss data width in bytes (≥1).
- USER_BITS, 1: ss user sideband width.
- LEN_BITS, 16: packet byte-length counter width.
- CNT_BITS, 32: statistics counter width.
- LFSR_SEED, 16'hACE1: backpressure LFSR reset value (must be nonzero).

Ports:
- clk  in  1  clock for all logic.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  master presents a beat.
- s_ready  out  1  checker accepts the beat this cycle.
- s_data  in  8*NUM_BYTES  beat data, big endian; byte 0 is [8*NUM_BYTES-1 -: 8].
- s_keep  in  NUM_BYTES  valid-byte mask on the last beat, big endian (MSB = byte 0).
- s_last  in  1  last beat of packet.
- s_user  in  USER_BITS  packet sideband, sampled on the first beat.
- bp_en  in  1  1 = pseudo-random ready, 0 = ready always high.
- res_valid  out  1  one-cycle pulse: a packet result is available.
- res_len  out  LEN_BITS  packet byte count, saturating at all-ones.
- res_err  out  1  packet failed a pattern or keep check.
- res_user  out  USER_BITS  s_user captured on the packet's first beat.
- pkt_cnt  out  CNT_BITS  packets completed, saturating.
- err_cnt  out  CNT_BITS  packets with res_err set, saturating.

## Operation
- A beat transfers when s_valid && s_ready; nothing changes state on a non-transfer cycle.
- States: IDLE (expecting first beat) and BODY (mid-packet). IDLE→BODY on a transferred beat with s_last=0. BODY→IDLE on a transferred beat with s_last=1. A single-beat packet stays in IDLE.
- First beat: seed = byte 0. The expected value for byte i of the packet is (seed + i) mod 256. res_user is captured from s_user.
- Each transferred byte is compared only if it is valid. All bytes of a non-last beat are valid. On a last beat, byte j is valid iff s_keep[NUM_BYTES-1-j].
- Keep rules:
  - Non-last beat: s_keep must be all ones.
  - Last beat: s_keep must be a nonzero MSB-aligned thermometer (1…10…0).
  - A violation sets the packet error. On a malformed last keep, the length adds the popcount of s_keep.
- Length accumulates the valid bytes per beat and saturates at 2^LEN_BITS-1. Saturation alone is not an error.
- The error flag is sticky within a packet and clears at packet start.
- Ready:
  - bp_en=0: s_ready=1.
  - bp_en=1: s_ready = LFSR bit 0.
  - The LFSR is a 16-bit Fibonacci x^16+x^14+x^13+x^11+1 (taps [15],[13],[12],[10] XOR into bit 0 after a left shift). It advances every cycle regardless of bp_en.
  - s_ready may drop while s_valid is high; this is legal for a slave.
- Counters increment by 1 per completed packet (err_cnt only when errored) and hold at all-ones.

## Timing
- Reset (rst=0, asynchronous): state IDLE; s_ready=0; res_valid=0; res_len=0; res_err=0; res_user=0; pkt_cnt=0; err_cnt=0; LFSR=LFSR_SEED. The first ready assertion is one cycle after rst deasserts.
- s_ready is registered: it is driven from the LFSR register or a post-reset flop, with no combinational path from s_valid.
- Result latency is 1 cycle. res_valid, res_len, res_err and res_user update on the clock edge following the last-beat transfer. The results hold until the next packet completes, and res_valid is high for exactly one cycle.
- pkt_cnt and err_cnt update on the same edge as res_valid.
- Back-to-back packets, where the last beat is followed by the next first beat in the next cycle, are accepted with no bubble. A new first beat transferring in the same cycle that res_valid is high does not corrupt the previous result.
- If reset is asserted mid-packet, the partial packet is discarded with no result and no count. The next transferred beat is treated as a first beat.

## Test plan
- NUM_BYTES=4, bp_en=0: one 3-beat packet of bytes 0x10..0x1B, last keep=4'b1111, user=1 → res_valid one cycle later, res_len=12, res_err=0, res_user=1, pkt_cnt=1.
- Same, but last beat keep=4'b1100 → res_len=10, res_err=0. Corrupting byte 5 to 0xFF → res_err=1, err_cnt=1. The next clean packet → res_err=0.
- Malformed keep: last keep=4'b1010 → res_err=1, res_len = 8+2. A non-last beat with keep=4'b0111 → res_err=1.
- bp_en=1, 100 random-length packets held by a master that keeps data stable while stalled → every result is correct and pkt_cnt=100. s_ready matches the LFSR sequence from 0xACE1.
- 1-beat packets back-to-back, plus rst pulsed low mid-way through a 5-beat packet → no result for the aborted packet, counters are 0 after reset, and the next packet is checked normally.
- LEN_BITS=4 with a 20-byte packet → res_len=15, res_err=0. A CNT_BITS=2 build with 5 packets → pkt_cnt=3.
